// File: rtl/line_memory.sv
// Dual-port line memory: port 1 serves read-only line fills, port 2 serves
// line fills and writebacks, both with a fixed programmable latency.
module line_memory #(
    parameter int LATENCY        = 4,
    parameter int LINE_ADDR_BITS = 10
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        readM1,
    input  logic [15:0] address1,
    output logic [63:0] data1,
    output logic        M1busy,
    input  logic        readM2,
    input  logic        writeM2,
    input  logic [15:0] address2,
    inout  wire  [63:0] data2,
    output logic        M2busy
);

    localparam int LINES = 1 << LINE_ADDR_BITS;
    localparam logic [3:0] LOAD =
        (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    logic [63:0] mem [0:LINES-1];

    state_t st1;
    state_t st2;
    logic [3:0] cnt1;
    logic [3:0] cnt2;
    logic [LINE_ADDR_BITS-1:0] line1;
    logic [LINE_ADDR_BITS-1:0] line2;
    logic [LINE_ADDR_BITS-1:0] req_line1;
    logic [LINE_ADDR_BITS-1:0] req_line2;
    logic op2;
    logic req2;
    logic abort1;
    logic abort2;
    logic drv2;
    logic unused_addr;

    assign req_line1 = address1[LINE_ADDR_BITS+1:2];
    assign req_line2 = address2[LINE_ADDR_BITS+1:2];
    assign req2      = readM2 | writeM2;
    // Word-offset and alias bits carry no meaning here.
    assign unused_addr = ^{address1, address2};

    // A request is abandoned if it drops or its line/op changes.
    assign abort1 = !readM1 || (req_line1 != line1);
    assign abort2 = !req2 || (req_line2 != line2) || (writeM2 != op2);

    // Port 1 sequencer: accept, count down latency, present one line.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            st1   <= IDLE;
            cnt1  <= 4'd0;
            line1 <= '0;
        end else begin
            case (st1)
                IDLE: if (readM1) begin
                    line1 <= req_line1;
                    cnt1  <= LOAD;
                    st1   <= (LATENCY == 1) ? DONE : WAIT;
                end
                WAIT: begin
                    if (abort1)
                        st1 <= IDLE;
                    else if (cnt1 == 4'd0)
                        st1 <= DONE;
                    else
                        cnt1 <= cnt1 - 4'd1;
                end
                default: st1 <= IDLE;
            endcase
        end
    end

    // Port 2 sequencer: same timing, plus the latched read/write op.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            st2   <= IDLE;
            cnt2  <= 4'd0;
            line2 <= '0;
            op2   <= 1'b0;
        end else begin
            case (st2)
                IDLE: if (req2) begin
                    line2 <= req_line2;
                    op2   <= writeM2;
                    cnt2  <= LOAD;
                    st2   <= (LATENCY == 1) ? DONE : WAIT;
                end
                WAIT: begin
                    if (abort2)
                        st2 <= IDLE;
                    else if (cnt2 == 4'd0)
                        st2 <= DONE;
                    else
                        cnt2 <= cnt2 - 4'd1;
                end
                default: st2 <= IDLE;
            endcase
        end
    end

    // Writeback commit on the edge leaving DONE; reset clears st2 first.
    always_ff @(posedge Clk) begin
        if (st2 == DONE && op2 && !abort2)
            mem[line2] <= data2;
    end

    // Busy is forced low while reset is held, even with a request up.
    assign M1busy = Reset_N & readM1 & (st1 != DONE);
    assign M2busy = Reset_N & req2 & (st2 != DONE);

    // Reads are combinational from the array, so a same-edge write is unseen.
    assign data1 = (st1 == DONE) ? mem[line1] : 64'd0;
    assign drv2  = (st2 == DONE) && !op2;
    assign data2 = drv2 ? mem[line2] : {64{1'bz}};

endmodule

// File: tb/tb_line_memory.sv
// Directed and randomized bench for line_memory, checked against a
// transaction-level model of the line array and the fixed request latency.
module tb_line_memory;

    localparam int LAT = 4;
    localparam int LAB = 10;
    localparam int NL  = 1 << LAB;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset_N;
    logic        readM1;
    logic [15:0] address1;
    logic [63:0] data1;
    logic        M1busy;
    logic        readM2;
    logic        writeM2;
    logic [15:0] address2;
    wire  [63:0] data2;
    logic        M2busy;
    logic [63:0] d2_val;
    logic        d2_en;

    logic        readM1_b;
    logic [15:0] address1_b;
    logic [63:0] data1_b;
    logic        M1busy_b;
    logic        readM2_b;
    logic        writeM2_b;
    logic [15:0] address2_b;
    wire  [63:0] data2_b;
    logic        M2busy_b;
    logic [63:0] d2_val_b;
    logic        d2_en_b;

    assign data2   = d2_en   ? d2_val   : {64{1'bz}};
    assign data2_b = d2_en_b ? d2_val_b : {64{1'bz}};

    line_memory #(.LATENCY(LAT), .LINE_ADDR_BITS(LAB)) dut (
        .Clk(Clk), .Reset_N(Reset_N),
        .readM1(readM1), .address1(address1),
        .data1(data1), .M1busy(M1busy),
        .readM2(readM2), .writeM2(writeM2),
        .address2(address2), .data2(data2), .M2busy(M2busy)
    );

    line_memory #(.LATENCY(1), .LINE_ADDR_BITS(LAB)) dut1 (
        .Clk(Clk), .Reset_N(Reset_N),
        .readM1(readM1_b), .address1(address1_b),
        .data1(data1_b), .M1busy(M1busy_b),
        .readM2(readM2_b), .writeM2(writeM2_b),
        .address2(address2_b), .data2(data2_b), .M2busy(M2busy_b)
    );

    int total = 0;
    int bad = 0;
    logic [63:0] ref_mem [NL];
    logic [63:0] ref1 [NL];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [15:0] addr_of(int line);
        logic [3:0] hi;
        logic [1:0] lo;
        hi = 4'($urandom);
        lo = 2'($urandom);
        return {hi, 10'(line), lo};
    endfunction

    // Hold readM1 for n back-to-back line reads of one address.
    task automatic p1_read(logic [15:0] a, int n);
        int line;
        line = int'(a[LAB+1:2]);
        readM1 = 1'b1;
        address1 = a;
        for (int t = 0; t < n; t++) begin
            for (int c = 0; c <= LAT; c++) begin
                @(negedge Clk);
                if (c < LAT) begin
                    check("p1_busy", 64'(M1busy), 64'd1);
                    check("p1_data_idle", data1, 64'd0);
                end else begin
                    check("p1_busy_done", 64'(M1busy), 64'd0);
                    check("p1_data", data1, ref_mem[line]);
                end
                step();
            end
        end
        readM1 = 1'b0;
        @(negedge Clk);
        check("p1_busy_after", 64'(M1busy), 64'd0);
        check("p1_data_after", data1, 64'd0);
        step();
    endtask

    task automatic p2_write(logic [15:0] a, logic [63:0] v, logic rd_too);
        int line;
        line = int'(a[LAB+1:2]);
        writeM2 = 1'b1;
        readM2 = rd_too;
        address2 = a;
        d2_en = 1'b1;
        d2_val = v;
        for (int c = 0; c <= LAT; c++) begin
            @(negedge Clk);
            check("p2w_drive", 64'(dut.drv2), 64'd0);
            check("p2w_busy", 64'(M2busy), (c < LAT) ? 64'd1 : 64'd0);
            step();
        end
        ref_mem[line] = v;
        writeM2 = 1'b0;
        readM2 = 1'b0;
        d2_en = 1'b0;
        @(negedge Clk);
        check("p2w_busy_after", 64'(M2busy), 64'd0);
        check("p2w_release", 64'(dut.drv2), 64'd0);
        step();
    endtask

    task automatic p2_read(logic [15:0] a);
        int line;
        line = int'(a[LAB+1:2]);
        readM2 = 1'b1;
        address2 = a;
        for (int c = 0; c <= LAT; c++) begin
            @(negedge Clk);
            if (c < LAT) begin
                check("p2r_busy", 64'(M2busy), 64'd1);
                check("p2r_drive_idle", 64'(dut.drv2), 64'd0);
            end else begin
                check("p2r_busy_done", 64'(M2busy), 64'd0);
                check("p2r_drive", 64'(dut.drv2), 64'd1);
                check("p2r_data", data2, ref_mem[line]);
            end
            step();
        end
        readM2 = 1'b0;
        @(negedge Clk);
        check("p2r_release", 64'(dut.drv2), 64'd0);
        step();
    endtask

    initial begin
        logic [63:0] v;
        logic [63:0] nv;
        int op;
        int line;

        Reset_N = 1'b0;
        readM1 = 1'b1; address1 = 16'h0000;
        readM2 = 1'b1; writeM2 = 1'b0; address2 = 16'h0000;
        d2_en = 1'b0; d2_val = 64'd0;
        readM1_b = 1'b0; address1_b = 16'h0000;
        readM2_b = 1'b0; writeM2_b = 1'b0; address2_b = 16'h0000;
        d2_en_b = 1'b0; d2_val_b = 64'd0;

        for (int i = 0; i < NL; i++) begin
            v = {$urandom, $urandom};
            dut.mem[i] = v;
            ref_mem[i] = v;
            dut1.mem[i] = v;
            ref1[i] = v;
        end
        dut.mem[5] = 64'h1111_2222_3333_4444;
        ref_mem[5] = 64'h1111_2222_3333_4444;

        // Reset state, with requests held high to prove busy is gated.
        step();
        @(negedge Clk);
        check("rst_m1busy", 64'(M1busy), 64'd0);
        check("rst_m2busy", 64'(M2busy), 64'd0);
        check("rst_data1", data1, 64'd0);
        check("rst_drive2", 64'(dut.drv2), 64'd0);
        readM1 = 1'b0;
        readM2 = 1'b0;
        @(negedge Clk);
        Reset_N = 1'b1;
        step();

        // 1: line 5 fill, held for a second back-to-back transfer.
        p1_read(16'h0016, 2);

        // 2: writeback to line 8, then a port-2 fill of the same line.
        p2_write(16'h0021, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        p2_read(16'h0020);

        // 3: address change mid-wait restarts from the following cycle.
        readM2 = 1'b1;
        address2 = addr_of(3);
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            check("chg_busy_pre", 64'(M2busy), 64'd1);
            step();
        end
        address2 = addr_of(7);
        for (int c = 2; c <= 3 + LAT; c++) begin
            @(negedge Clk);
            if (c < 3 + LAT) begin
                check("chg_busy", 64'(M2busy), 64'd1);
                check("chg_drive_idle", 64'(dut.drv2), 64'd0);
            end else begin
                check("chg_busy_done", 64'(M2busy), 64'd0);
                check("chg_drive", 64'(dut.drv2), 64'd1);
                check("chg_data", data2, ref_mem[7]);
            end
            step();
        end
        readM2 = 1'b0;
        step();

        // 4: read and write together behave as a write.
        p2_write(addr_of(9), 64'h0123_4567_89AB_CDEF, 1'b1);
        p1_read(addr_of(9), 1);

        // 5: asynchronous reset in the middle of a write to line 4.
        writeM2 = 1'b1;
        address2 = addr_of(4);
        d2_en = 1'b1;
        d2_val = ~ref_mem[4];
        step();
        step();
        #2;
        Reset_N = 1'b0;
        #1;
        check("mid_rst_busy", 64'(M2busy), 64'd0);
        check("mid_rst_drive", 64'(dut.drv2), 64'd0);
        writeM2 = 1'b0;
        d2_en = 1'b0;
        step();
        @(negedge Clk);
        Reset_N = 1'b1;
        step();
        p1_read(addr_of(4), 1);
        p2_read(addr_of(4));

        // Randomized traffic over a small set of lines.
        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 2));
            line = int'($urandom_range(0, 15));
            nv = {$urandom, $urandom};
            if (op == 0)
                p1_read(addr_of(line), 1);
            else if (op == 1)
                p2_read(addr_of(line));
            else
                p2_write(addr_of(line), nv, 1'($urandom));
        end

        // 6: LATENCY=1 instance, same-cycle read and write of line 0.
        nv = ~ref1[0];
        readM1_b = 1'b1;
        address1_b = addr_of(0);
        writeM2_b = 1'b1;
        address2_b = addr_of(0);
        d2_en_b = 1'b1;
        d2_val_b = nv;
        @(negedge Clk);
        check("l1_m1busy_c0", 64'(M1busy_b), 64'd1);
        check("l1_m2busy_c0", 64'(M2busy_b), 64'd1);
        check("l1_data1_c0", data1_b, 64'd0);
        step();
        @(negedge Clk);
        check("l1_m1busy_c1", 64'(M1busy_b), 64'd0);
        check("l1_m2busy_c1", 64'(M2busy_b), 64'd0);
        check("l1_old_data", data1_b, ref1[0]);
        step();
        ref1[0] = nv;
        readM1_b = 1'b0;
        writeM2_b = 1'b0;
        d2_en_b = 1'b0;
        step();
        readM1_b = 1'b1;
        address1_b = addr_of(0);
        @(negedge Clk);
        check("l1_reread_busy", 64'(M1busy_b), 64'd1);
        step();
        @(negedge Clk);
        check("l1_reread_done", 64'(M1busy_b), 64'd0);
        check("l1_new_data", data1_b, ref1[0]);
        step();
        readM1_b = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
